// File: rtl/cmp_stim_gen_pkg.sv
// Shared definitions for the equality-comparator stimulus sequencer:
// FSM encodings, the Gray-ordered vector table and the reference model.
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // (x,y) per vector index; neighbouring entries differ in one bit and the
  // last entry is one bit away from the first, so passes also wrap in Gray order.
  localparam logic [1:0] GRAY_TABLE [0:3] = '{2'b00, 2'b10, 2'b11, 2'b01};

  // Look up the {x,y} pair presented for a vector index.
  function automatic logic [1:0] gray_vec(input logic [1:0] idx);
    return GRAY_TABLE[idx];
  endfunction

  // Reference result of the 1-bit equality comparator.
  function automatic logic exp_z(input logic x, input logic y);
    return ~(x ^ y);
  endfunction

endpackage

// File: rtl/cmp_stim_gen_hold_timer.sv
// Loadable down-counter that measures how long each vector is held.
// tc marks the last cycle of a hold window (count 0).
module hold_timer #(
  parameter int HOLD = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  // HOLD >= 2, so HOLD-1 always fits in $clog2(HOLD) bits.
  localparam int TW = $clog2(HOLD);

  logic [TW-1:0] count_r;

  // Load the window length on a new vector, otherwise count down to 0 and stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {TW{1'b0}};
    end else if (load) begin
      count_r <= TW'(HOLD - 1);
    end else if (en && (count_r != {TW{1'b0}})) begin
      count_r <= count_r - {{(TW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == {TW{1'b0}});

endmodule

// File: rtl/cmp_stim_gen.sv
// Stimulus sequencer and checker for a 1-bit equality comparator.
// Walks x/y through the Gray-ordered vectors REPEAT times, holding each for
// HOLD cycles, samples z in the last cycle of each window and keeps
// saturating vector/mismatch counts plus a sticky error flag.
module cmp_stim_gen
  import cmp_pkg::*;
#(
  parameter int HOLD   = 20,
  parameter int REPEAT = 1,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          z,
  output logic          x,
  output logic          y,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] vec_cnt,
  output logic [CW-1:0] err_cnt,
  output logic          err
);

  localparam int PW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [PW-1:0] LAST_PASS = PW'(REPEAT - 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

  state_e        state_r, state_s;
  logic [1:0]    idx_r, idx_s;
  logic [PW-1:0] pass_r, pass_s;
  logic          x_r, x_s, y_r, y_s;
  logic          busy_r, busy_s, done_r, done_s;
  logic [CW-1:0] vec_cnt_r, vec_cnt_s, err_cnt_r, err_cnt_s;
  logic          err_r, err_s;
  logic          load_s, en_s, tc_s;

  hold_timer #(.HOLD(HOLD)) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .load (load_s),
    .en   (en_s),
    .tc   (tc_s)
  );

  assign en_s = (state_r == ST_DRIVE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state plus next values of every registered output and counter.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    pass_s    = pass_r;
    x_s       = x_r;
    y_s       = y_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    vec_cnt_s = vec_cnt_r;
    err_cnt_s = err_cnt_r;
    err_s     = err_r;
    load_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        x_s    = 1'b0;
        y_s    = 1'b0;
        busy_s = 1'b0;
        if (start) begin
          state_s    = ST_DRIVE;
          idx_s      = 2'd0;
          pass_s     = {PW{1'b0}};
          {x_s, y_s} = gray_vec(2'd0);
          busy_s     = 1'b1;
          vec_cnt_s  = {CW{1'b0}};
          err_cnt_s  = {CW{1'b0}};
          err_s      = 1'b0;
          load_s     = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (tc_s) begin
          // Last cycle of the window: z reflects the vector currently on x/y.
          vec_cnt_s = (vec_cnt_r == CNT_MAX) ? vec_cnt_r : vec_cnt_r + CNT_ONE;
          if (z != exp_z(x_r, y_r)) begin
            err_cnt_s = (err_cnt_r == CNT_MAX) ? err_cnt_r : err_cnt_r + CNT_ONE;
            err_s     = 1'b1;
          end else begin
            err_cnt_s = err_cnt_r;
          end
          if ((idx_r == 2'd3) && (pass_r == LAST_PASS)) begin
            state_s = ST_DONE;
            x_s     = 1'b0;
            y_s     = 1'b0;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            idx_s      = idx_r + 2'd1;
            pass_s     = (idx_r == 2'd3) ? pass_r + {{(PW-1){1'b0}}, 1'b1} : pass_r;
            {x_s, y_s} = gray_vec(idx_r + 2'd1);
            load_s     = 1'b1;
          end
        end else begin
          state_s = ST_DRIVE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        x_s     = 1'b0;
        y_s     = 1'b0;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        x_s     = 1'b0;
        y_s     = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r     <= 2'd0;
      pass_r    <= {PW{1'b0}};
      x_r       <= 1'b0;
      y_r       <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      vec_cnt_r <= {CW{1'b0}};
      err_cnt_r <= {CW{1'b0}};
      err_r     <= 1'b0;
    end else begin
      idx_r     <= idx_s;
      pass_r    <= pass_s;
      x_r       <= x_s;
      y_r       <= y_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      vec_cnt_r <= vec_cnt_s;
      err_cnt_r <= err_cnt_s;
      err_r     <= err_s;
    end
  end

  assign x       = x_r;
  assign y       = y_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign vec_cnt = vec_cnt_r;
  assign err_cnt = err_cnt_r;
  assign err     = err_r;

endmodule

// File: tb/tb_cmp_stim_gen.sv
// Bench for cmp_stim_gen: three instances with different HOLD/REPEAT/CW,
// each driving a modelled comparator (correct XNOR, z stuck at 0, or XOR).
module tb_cmp_stim_gen;

  localparam logic [1:0] M_XNOR = 2'd0;
  localparam logic [1:0] M_ZERO = 2'd1;
  localparam logic [1:0] M_XOR  = 2'd2;

  logic       clk = 1'b0;
  logic [2:0] start_v = 3'b000;
  logic [2:0] rst_v   = 3'b111;
  logic [1:0] mode_v [3];
  logic [2:0] x_v, y_v, z_v, busy_v, done_v, err_v;
  logic [7:0] vec_v [3];
  logic [7:0] ec_v [3];
  logic [1:0] vec_b, ec_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         dut;
    int         hold;
    int         rep;
    logic [1:0] mode;
    logic [7:0] vec;
    logic [7:0] ecnt;
    logic       flag;
    bit         hold_start;
  } vec_t;

  typedef struct {
    logic [7:0] vec;
    logic [7:0] ecnt;
    logic       flag;
    int         busy;
  } exp_t;

  exp_t sb_q [$];
  vec_t tbl [8];

  always #5 clk = ~clk;

  // Comparator models feeding z back to each instance.
  for (genvar i = 0; i < 3; i++) begin : g_cmp
    assign z_v[i] = (mode_v[i] == M_XNOR) ? ~(x_v[i] ^ y_v[i]) :
                    (mode_v[i] == M_XOR)  ?  (x_v[i] ^ y_v[i]) : 1'b0;
  end

  assign vec_v[1] = {6'd0, vec_b};
  assign ec_v[1]  = {6'd0, ec_b};

  cmp_stim_gen #(.HOLD(4), .REPEAT(1), .CW(8)) dut_a (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .z(z_v[0]),
    .x(x_v[0]), .y(y_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .vec_cnt(vec_v[0]), .err_cnt(ec_v[0]), .err(err_v[0]));

  cmp_stim_gen #(.HOLD(2), .REPEAT(3), .CW(2)) dut_b (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .z(z_v[1]),
    .x(x_v[1]), .y(y_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .vec_cnt(vec_b), .err_cnt(ec_b), .err(err_v[1]));

  cmp_stim_gen #(.HOLD(2), .REPEAT(2), .CW(8)) dut_c (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .z(z_v[2]),
    .x(x_v[2]), .y(y_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .vec_cnt(vec_v[2]), .err_cnt(ec_v[2]), .err(err_v[2]));

  function automatic logic [1:0] gray_xy(input int i);
    case (i % 4)
      0: return 2'b00;
      1: return 2'b10;
      2: return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete run: expectation pushed at start, popped when done appears.
  task automatic run(input vec_t v);
    exp_t e;
    int   c, nbusy, bound, xy_bad;
    bit   seen;
    e.vec = v.vec; e.ecnt = v.ecnt; e.flag = v.flag; e.busy = 4 * v.rep * v.hold;
    sb_q.push_back(e);
    mode_v[v.dut]  = v.mode;
    start_v[v.dut] = 1'b1;
    step();
    c = 1; nbusy = 0; xy_bad = 0; seen = 1'b0;
    bound = e.busy + 10;
    while (c <= bound) begin
      if (!v.hold_start) start_v[v.dut] = 1'b0;
      if (done_v[v.dut]) begin
        seen = 1'b1;
        break;
      end
      if (busy_v[v.dut]) begin
        nbusy++;
        if ({x_v[v.dut], y_v[v.dut]} !== gray_xy((c - 1) / v.hold)) xy_bad++;
      end
      step();
      c++;
    end
    e = sb_q.pop_front();
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("xy_sequence", 32'(xy_bad), 32'd0);
      chk("busy_cycles", 32'(nbusy), 32'(e.busy));
      chk("done_cycle", 32'(c), 32'(e.busy + 1));
      chk("done_busy_xy", {29'd0, busy_v[v.dut], x_v[v.dut], y_v[v.dut]}, 32'd0);
      chk("vec_cnt", 32'(vec_v[v.dut]), 32'(e.vec));
      chk("err_cnt", 32'(ec_v[v.dut]), 32'(e.ecnt));
      chk("err_flag", 32'(err_v[v.dut]), 32'(e.flag));
      step();
      chk("idle_after_done", {30'd0, done_v[v.dut], busy_v[v.dut]}, 32'd0);
      chk("vec_cnt_hold", 32'(vec_v[v.dut]), 32'(e.vec));
      if (v.hold_start) begin
        step();
        chk("restart_busy", 32'(busy_v[v.dut]), 32'd1);
        start_v[v.dut] = 1'b0;
        rst_v[v.dut]   = 1'b1;
        step();
        rst_v[v.dut]   = 1'b0;
      end
    end else begin
      start_v[v.dut] = 1'b0;
      rst_v[v.dut]   = 1'b1;
      step();
      rst_v[v.dut]   = 1'b0;
    end
    step();
  endtask

  initial begin : main
    int ndone;
    tbl[0] = '{0, 4, 1, M_XNOR, 8'd4, 8'd0, 1'b0, 1'b0};
    tbl[1] = '{0, 4, 1, M_ZERO, 8'd4, 8'd2, 1'b1, 1'b0};
    tbl[2] = '{0, 4, 1, M_XOR,  8'd4, 8'd4, 1'b1, 1'b0};
    tbl[3] = '{1, 2, 3, M_ZERO, 8'd3, 8'd3, 1'b1, 1'b0};
    tbl[4] = '{1, 2, 3, M_XNOR, 8'd3, 8'd0, 1'b0, 1'b0};
    tbl[5] = '{2, 2, 2, M_XNOR, 8'd8, 8'd0, 1'b0, 1'b0};
    tbl[6] = '{2, 2, 2, M_XOR,  8'd8, 8'd8, 1'b1, 1'b0};
    tbl[7] = '{0, 4, 1, M_XNOR, 8'd4, 8'd0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) mode_v[i] = M_XNOR;

    repeat (3) step();
    rst_v = 3'b000;
    for (int i = 0; i < 3; i++) begin
      chk("reset_state", {vec_v[i], ec_v[i], 11'd0, x_v[i], y_v[i], busy_v[i], done_v[i], err_v[i]}, 32'd0);
    end
    step();

    for (int i = 0; i < 8; i++) run(tbl[i]);

    // Reset in cycle 6 of a run on instance A.
    mode_v[0]  = M_XNOR;
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    repeat (5) step();
    chk("mid_run_busy", 32'(busy_v[0]), 32'd1);
    chk("mid_run_vec", 32'(vec_v[0]), 32'd1);
    rst_v[0] = 1'b1;
    step();
    rst_v[0] = 1'b0;
    chk("rst_clears", {vec_v[0], ec_v[0], 12'd0, x_v[0], y_v[0], busy_v[0], err_v[0]}, 32'd0);
    ndone = 0;
    repeat (30) begin
      if (done_v[0]) ndone++;
      step();
    end
    chk("no_done_after_rst", 32'(ndone), 32'd0);

    // rst and start on the same edge: rst wins and start is not remembered.
    rst_v[0]   = 1'b1;
    start_v[0] = 1'b1;
    step();
    chk("rst_beats_start", 32'(busy_v[0]), 32'd0);
    rst_v[0]   = 1'b0;
    start_v[0] = 1'b0;
    step();
    chk("start_not_queued", 32'(busy_v[0]), 32'd0);

    // Fresh run completes normally after the aborted one.
    run(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
